// File: rtl/rgb24_to_rgb8_quantizer_if.sv
// ----------------------------------------------------------------------------
// rgb24_to_rgb8_quantizer_if
//   Stream bundle for the RGB888 -> RGB332/RGB222 quantizer. It carries the
//   input beat (pixel, mode, sideband, valid/ready) and the output beat
//   (packed pixel, sideband, valid/ready).
//   master : environment side, which drives input beats and the output ready.
//   slave  : quantizer side, which accepts input beats and drives output beats.
// Signals
//   i_valid, o_ready      input handshake
//   i_rgb24Pixel[23:0]    R[23:16] G[15:8] B[7:0]
//   i_mode                0: RGB332, 1: RGB222
//   i_sof, i_eol          first pixel of frame / last pixel of line
//   o_valid, i_ready      output handshake
//   o_rgb8Pixel[7:0]      RGB332 {R3,G3,B2} or RGB222 {2'b00,R2,G2,B2}
//   o_sof, o_eol          sideband aligned with o_rgb8Pixel
// ----------------------------------------------------------------------------
interface rgb24_to_rgb8_quantizer_if;
  logic        i_valid;
  logic        o_ready;
  logic [23:0] i_rgb24Pixel;
  logic        i_mode;
  logic        i_sof;
  logic        i_eol;
  logic        o_valid;
  logic        i_ready;
  logic [7:0]  o_rgb8Pixel;
  logic        o_sof;
  logic        o_eol;

  modport master (
    output i_valid, i_rgb24Pixel, i_mode, i_sof, i_eol, i_ready,
    input  o_ready, o_valid, o_rgb8Pixel, o_sof, o_eol
  );

  modport slave (
    input  i_valid, i_rgb24Pixel, i_mode, i_sof, i_eol, i_ready,
    output o_ready, o_valid, o_rgb8Pixel, o_sof, o_eol
  );
endinterface

// File: rtl/rgb24_to_rgb8_quantizer.sv
// ----------------------------------------------------------------------------
// rgb24_to_rgb8_quantizer
//   Streaming RGB888 -> RGB332 / RGB222 down-converter with an optional 4x4
//   ordered (Bayer) dither. Two-stage pipeline, 1 pixel/clk, valid/ready on
//   both sides.
// Parameters
//   DITHER_EN  1: threshold taken from pixel position; 0: fixed d = 128
// Ports
//   i_clk      pixel clock
//   i_rst      synchronous active-high reset
//   io_stream  stream bundle (slave modport): input beat + output beat
// ----------------------------------------------------------------------------
module rgb24_to_rgb8_quantizer #(
  parameter bit DITHER_EN = 1'b1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  rgb24_to_rgb8_quantizer_if.slave       io_stream
);

  // Pipeline state
  logic       r_s1_valid;
  logic [7:0] r_s1_r;
  logic [7:0] r_s1_g;
  logic [7:0] r_s1_b;
  logic [7:0] r_s1_d;
  logic       r_s1_mode;
  logic       r_s1_sof;
  logic       r_s1_eol;

  logic       r_o_valid;
  logic [7:0] r_o_pix;
  logic       r_o_sof;
  logic       r_o_eol;

  // Bayer position within the 4x4 tile
  logic [1:0] r_x;
  logic [1:0] r_y;

  logic       w_en;
  logic       w_acc;
  logic [1:0] w_x;
  logic [1:0] w_y;
  logic [3:0] w_m;
  logic [7:0] w_d;
  logic [7:0] w_pix;

  // 3-bit level: (v*7 + d) >> 8, clamped to 7
  function automatic logic [2:0] quant3(input logic [7:0] v, input logic [7:0] d);
    logic [11:0] acc;
    logic [3:0]  lvl;
    acc = 12'(v) * 12'd7 + 12'(d);
    lvl = 4'(acc >> 8);
    return (lvl > 4'd7) ? 3'd7 : lvl[2:0];
  endfunction

  // 2-bit level: (v*3 + d) >> 8, clamped to 3
  function automatic logic [1:0] quant2(input logic [7:0] v, input logic [7:0] d);
    logic [11:0] acc;
    logic [3:0]  lvl;
    acc = 12'(v) * 12'd3 + 12'(d);
    lvl = 4'(acc >> 8);
    return (lvl > 4'd3) ? 2'd3 : lvl[1:0];
  endfunction

  // Output register empty or being drained -> whole pipe may shift
  assign w_en  = !r_o_valid | io_stream.i_ready;
  assign w_acc = io_stream.i_valid & w_en;

  // A start-of-frame beat is placed at tile origin regardless of the counters
  assign w_x = io_stream.i_sof ? 2'd0 : r_x;
  assign w_y = io_stream.i_sof ? 2'd0 : r_y;

  always_comb begin
    w_m = 4'd0;
    case ({w_y, w_x})
      4'h0: w_m = 4'd0;
      4'h1: w_m = 4'd8;
      4'h2: w_m = 4'd2;
      4'h3: w_m = 4'd10;
      4'h4: w_m = 4'd12;
      4'h5: w_m = 4'd4;
      4'h6: w_m = 4'd14;
      4'h7: w_m = 4'd6;
      4'h8: w_m = 4'd3;
      4'h9: w_m = 4'd11;
      4'hA: w_m = 4'd1;
      4'hB: w_m = 4'd9;
      4'hC: w_m = 4'd15;
      4'hD: w_m = 4'd7;
      4'hE: w_m = 4'd13;
      4'hF: w_m = 4'd5;
      default: w_m = 4'd0;
    endcase
  end

  // d = 16*M + 8 spreads thresholds evenly over 8..248
  assign w_d = DITHER_EN ? {w_m, 4'b1000} : 8'd128;

  always_comb begin
    w_pix = 8'd0;
    if (r_s1_mode)
      w_pix = {2'b00, quant2(r_s1_r, r_s1_d), quant2(r_s1_g, r_s1_d), quant2(r_s1_b, r_s1_d)};
    else
      w_pix = {quant3(r_s1_r, r_s1_d), quant3(r_s1_g, r_s1_d), quant2(r_s1_b, r_s1_d)};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x        <= 2'd0;
      r_y        <= 2'd0;
      r_s1_valid <= 1'b0;
      r_s1_r     <= 8'd0;
      r_s1_g     <= 8'd0;
      r_s1_b     <= 8'd0;
      r_s1_d     <= 8'd0;
      r_s1_mode  <= 1'b0;
      r_s1_sof   <= 1'b0;
      r_s1_eol   <= 1'b0;
      r_o_valid  <= 1'b0;
      r_o_pix    <= 8'd0;
      r_o_sof    <= 1'b0;
      r_o_eol    <= 1'b0;
    end else begin
      if (w_acc) begin
        if (io_stream.i_eol) begin
          r_x <= 2'd0;
          r_y <= w_y + 2'd1;
        end else begin
          r_x <= w_x + 2'd1;
          r_y <= w_y;
        end
      end

      if (w_en) begin
        r_s1_valid <= io_stream.i_valid;
        if (io_stream.i_valid) begin
          r_s1_r    <= io_stream.i_rgb24Pixel[23:16];
          r_s1_g    <= io_stream.i_rgb24Pixel[15:8];
          r_s1_b    <= io_stream.i_rgb24Pixel[7:0];
          r_s1_d    <= w_d;
          r_s1_mode <= io_stream.i_mode;
          r_s1_sof  <= io_stream.i_sof;
          r_s1_eol  <= io_stream.i_eol;
        end

        r_o_valid <= r_s1_valid;
        // Bubbles leave the last data word in place; only o_valid drops
        if (r_s1_valid) begin
          r_o_pix <= w_pix;
          r_o_sof <= r_s1_sof;
          r_o_eol <= r_s1_eol;
        end
      end
    end
  end

  assign io_stream.o_ready     = w_en;
  assign io_stream.o_valid     = r_o_valid;
  assign io_stream.o_rgb8Pixel = r_o_pix;
  assign io_stream.o_sof       = r_o_sof;
  assign io_stream.o_eol       = r_o_eol;

endmodule
